// File: rtl/dijkstra_relaxer.sv
// Dijkstra control and relaxation engine: owns the distance/visited vectors consumed by MinHeap,
// retires the reported minimum node and relaxes its outgoing edges from an external weight memory.
module dijkstra_relaxer #(
    parameter int MAX_NODES   = 8,
    parameter int INDEX_WIDTH = 3,
    parameter int VALUE_WIDTH = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    input  logic [INDEX_WIDTH-1:0]           source_index,
    input  logic                             min_ready,
    input  logic [INDEX_WIDTH-1:0]           sc_min_index,
    input  logic [VALUE_WIDTH-1:0]           sc_min_value,
    output logic                             set_en,
    output logic [MAX_NODES-1:0]             visited_vector,
    output logic [VALUE_WIDTH*MAX_NODES-1:0] dist_vector,
    output logic                             edge_rd_en,
    output logic [INDEX_WIDTH-1:0]           edge_src,
    output logic [INDEX_WIDTH-1:0]           edge_dst,
    input  logic [VALUE_WIDTH-1:0]           edge_weight,
    output logic                             busy,
    output logic                             done
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StInit    = 3'd1;
    localparam logic [2:0] StWaitMin = 3'd2;
    localparam logic [2:0] StCheck   = 3'd3;
    localparam logic [2:0] StRelax   = 3'd4;
    localparam logic [2:0] StDone    = 3'd5;

    localparam logic [VALUE_WIDTH-1:0] Inf     = '1;
    localparam logic [INDEX_WIDTH:0]   LastCol = (INDEX_WIDTH + 1)'(MAX_NODES);

    logic [2:0]             state_q, state_d;
    logic [VALUE_WIDTH-1:0] dist_q [MAX_NODES];
    logic [VALUE_WIDTH-1:0] dist_d [MAX_NODES];
    logic [MAX_NODES-1:0]   visited_q, visited_d;
    logic                   set_en_q, set_en_d;
    logic                   edge_rd_en_q, edge_rd_en_d;
    logic [INDEX_WIDTH-1:0] edge_src_q, edge_src_d;
    logic [INDEX_WIDTH-1:0] edge_dst_q, edge_dst_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   armed_q, armed_d;
    logic [INDEX_WIDTH-1:0] cur_q, cur_d;
    logic [VALUE_WIDTH-1:0] curd_q, curd_d;
    logic [INDEX_WIDTH:0]   col_q, col_d;
    logic                   eval_q, eval_d;
    logic [INDEX_WIDTH-1:0] eval_col_q, eval_col_d;

    // One extra bit so that a sum reaching or exceeding INF is detectable as saturated.
    logic [VALUE_WIDTH:0]   relax_sum;
    logic                   relax_upd;

    assign relax_sum = {1'b0, curd_q} + {1'b0, edge_weight};
    assign relax_upd = eval_q && (edge_weight != Inf) && !visited_q[eval_col_q] &&
                       (relax_sum < {1'b0, Inf}) &&
                       (relax_sum[VALUE_WIDTH-1:0] < dist_q[eval_col_q]);

    always_comb begin
        state_d      = state_q;
        dist_d       = dist_q;
        visited_d    = visited_q;
        set_en_d     = 1'b0;
        edge_rd_en_d = 1'b0;
        edge_src_d   = edge_src_q;
        edge_dst_d   = edge_dst_q;
        busy_d       = busy_q;
        done_d       = done_q;
        armed_d      = armed_q;
        cur_d        = cur_q;
        curd_d       = curd_q;
        col_d        = col_q;
        // Read data returns one cycle after the strobe, so evaluation trails the read by one.
        eval_d       = edge_rd_en_q;
        eval_col_d   = edge_dst_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    for (int i = 0; i < MAX_NODES; i++) begin
                        dist_d[i] = Inf;
                    end
                    dist_d[source_index] = '0;
                    visited_d = '0;
                    set_en_d  = 1'b1;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    state_d   = StInit;
                end
            end
            StInit: begin
                armed_d = 1'b0;
                state_d = StWaitMin;
            end
            StWaitMin: begin
                // The first low cycle after set_en proves the heap result is fresh.
                if (!min_ready) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    cur_d   = sc_min_index;
                    curd_d  = sc_min_value;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (curd_q == Inf) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    visited_d[cur_q] = 1'b1;
                    col_d            = '0;
                    edge_rd_en_d     = 1'b1;
                    edge_src_d       = cur_q;
                    edge_dst_d       = '0;
                    state_d          = StRelax;
                end
            end
            StRelax: begin
                if (relax_upd) begin
                    dist_d[eval_col_q] = relax_sum[VALUE_WIDTH-1:0];
                end
                col_d = col_q + 1'b1;
                if ((col_q + 1'b1) < LastCol) begin
                    edge_rd_en_d = 1'b1;
                    edge_dst_d   = col_q[INDEX_WIDTH-1:0] + 1'b1;
                end
                if (col_q == LastCol) begin
                    if (&visited_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        set_en_d = 1'b1;
                        armed_d  = 1'b0;
                        state_d  = StWaitMin;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            for (int i = 0; i < MAX_NODES; i++) begin
                dist_q[i] <= Inf;
            end
            visited_q    <= '0;
            set_en_q     <= 1'b0;
            edge_rd_en_q <= 1'b0;
            edge_src_q   <= '0;
            edge_dst_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            armed_q      <= 1'b0;
            cur_q        <= '0;
            curd_q       <= '0;
            col_q        <= '0;
            eval_q       <= 1'b0;
            eval_col_q   <= '0;
        end else begin
            state_q      <= state_d;
            dist_q       <= dist_d;
            visited_q    <= visited_d;
            set_en_q     <= set_en_d;
            edge_rd_en_q <= edge_rd_en_d;
            edge_src_q   <= edge_src_d;
            edge_dst_q   <= edge_dst_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            armed_q      <= armed_d;
            cur_q        <= cur_d;
            curd_q       <= curd_d;
            col_q        <= col_d;
            eval_q       <= eval_d;
            eval_col_q   <= eval_col_d;
        end
    end

    for (genvar g = 0; g < MAX_NODES; g++) begin : g_dist
        assign dist_vector[g*VALUE_WIDTH +: VALUE_WIDTH] = dist_q[g];
    end

    assign visited_vector = visited_q;
    assign set_en         = set_en_q;
    assign edge_rd_en     = edge_rd_en_q;
    assign edge_src       = edge_src_q;
    assign edge_dst       = edge_dst_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_dijkstra_relaxer.sv
// Directed bench for dijkstra_relaxer (4 nodes) with a behavioural MinHeap and edge memory.
module tb_dijkstra_relaxer;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int VW = 8;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [IW-1:0]   source_index = '0;
    logic            min_ready = 1'b0;
    logic [IW-1:0]   sc_min_index = '0;
    logic [VW-1:0]   sc_min_value = '0;
    logic [VW-1:0]   edge_weight = '0;
    logic            set_en;
    logic [N-1:0]    visited_vector;
    logic [N*VW-1:0] dist_vector;
    logic            edge_rd_en;
    logic [IW-1:0]   edge_src;
    logic [IW-1:0]   edge_dst;
    logic            busy;
    logic            done;

    dijkstra_relaxer #(.MAX_NODES(N), .INDEX_WIDTH(IW), .VALUE_WIDTH(VW)) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .source_index   (source_index),
        .min_ready      (min_ready),
        .sc_min_index   (sc_min_index),
        .sc_min_value   (sc_min_value),
        .set_en         (set_en),
        .visited_vector (visited_vector),
        .dist_vector    (dist_vector),
        .edge_rd_en     (edge_rd_en),
        .edge_src       (edge_src),
        .edge_dst       (edge_dst),
        .edge_weight    (edge_weight),
        .busy           (busy),
        .done           (done)
    );

    always #5 clock = ~clock;

    logic [VW-1:0] wmem [N][N];
    int            vecs = 0;
    int            errs = 0;

    // Environment monitors, written only by the model process below.
    int            sen_cnt = 0;
    int            rd_cnt = 0;
    int            src3_reads = 0;
    int            consec_err = 0;
    int            order[$];
    bit            stale_en = 1'b0;
    int            stale_sen = 0;
    int            settle = 0;
    int            stale_ph = 0;
    logic          prev_rd = 1'b0;
    logic [IW-1:0] prev_src = '0;
    logic [IW-1:0] prev_dst = '0;
    logic          prev_sen = 1'b0;
    logic [N-1:0]  prev_vis = '0;

    function automatic logic [VW-1:0] dist_of(input int i);
        return dist_vector[i*VW +: VW];
    endfunction

    // Edge memory and MinHeap model, driven mid-cycle so the DUT samples settled values.
    always @(negedge clock) begin
        int            bi;
        logic [VW-1:0] bv;
        bit            found;
        edge_weight = prev_rd ? wmem[prev_src][prev_dst] : 8'h00;
        prev_rd  = edge_rd_en;
        prev_src = edge_src;
        prev_dst = edge_dst;
        if (edge_rd_en) begin
            rd_cnt++;
            if (edge_src == 2'd3) src3_reads++;
        end
        if (set_en && prev_sen) consec_err++;
        prev_sen = set_en;
        for (int i = 0; i < N; i++) begin
            if (visited_vector[i] && !prev_vis[i]) order.push_back(i);
        end
        prev_vis = visited_vector;

        if (set_en) begin
            sen_cnt++;
            if (stale_en && sen_cnt == stale_sen) begin
                stale_ph     = 1;
                settle       = 0;
                min_ready    = 1'b1;
                sc_min_index = 2'd1;
                sc_min_value = dist_of(1);
            end else begin
                stale_ph  = 0;
                settle    = 3;
                min_ready = 1'b0;
            end
        end else if (stale_ph > 0) begin
            stale_ph++;
            if (stale_ph == 4) begin
                min_ready = 1'b0;
            end else if (stale_ph == 5) begin
                min_ready    = 1'b1;
                sc_min_index = 2'd2;
                sc_min_value = dist_of(2);
                stale_ph     = 0;
            end
        end else if (settle > 0) begin
            settle--;
            if (settle == 0) begin
                found = 1'b0;
                bi    = 0;
                bv    = 8'hFF;
                for (int i = 0; i < N; i++) begin
                    if (!visited_vector[i] && (!found || dist_of(i) < bv)) begin
                        found = 1'b1;
                        bv    = dist_of(i);
                        bi    = i;
                    end
                end
                sc_min_index = IW'(bi);
                sc_min_value = bv;
                min_ready    = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_graph();
        for (int s = 0; s < N; s++) begin
            for (int d = 0; d < N; d++) wmem[s][d] = 8'hFF;
        end
    endtask

    task automatic pulse_start(input logic [IW-1:0] src, input string tag);
        logic [N*VW-1:0] e;
        e = '1;
        e[src*VW +: VW] = '0;
        @(negedge clock);
        source_index = src;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk({tag, " init set_en"}, set_en, 1);
        chk({tag, " init busy"}, busy, 1);
        chk({tag, " init done"}, done, 0);
        chk({tag, " init dist"}, dist_vector, e);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 2000) begin
            @(negedge clock);
            n++;
        end
        chk({tag, " done"}, done, 1);
        chk({tag, " busy"}, busy, 0);
    endtask

    task automatic wait_relax(input string tag);
        int n;
        n = 0;
        while (!edge_rd_en && n < 2000) begin
            @(negedge clock);
            n++;
        end
        chk({tag, " relax reached"}, edge_rd_en, 1);
    endtask

    initial begin
        int b_sen, b_rd, b_s3, b_ord;
        clear_graph();
        repeat (2) @(negedge clock);
        chk("rst dist", dist_vector, 32'hFFFF_FFFF);
        chk("rst visited", visited_vector, 0);
        chk("rst set_en", set_en, 0);
        chk("rst edge_rd_en", edge_rd_en, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst edge_src", edge_src, 0);
        chk("rst edge_dst", edge_dst, 0);
        reset = 1'b1;

        // Graph 1: 0->1 w4, 0->2 w1, 2->1 w2, 1->3 w5.
        wmem[0][1] = 8'd4; wmem[0][2] = 8'd1; wmem[2][1] = 8'd2; wmem[1][3] = 8'd5;
        b_sen = sen_cnt; b_rd = rd_cnt; b_ord = order.size();
        pulse_start(2'd0, "g1");
        wait_done("g1");
        chk("g1 dist", dist_vector, 32'h0801_0300);
        chk("g1 visited", visited_vector, 4'b1111);
        chk("g1 set_en pulses", sen_cnt - b_sen, 4);
        chk("g1 edge reads", rd_cnt - b_rd, 16);
        chk("g1 second retired", order[b_ord + 1], 2);
        chk("g1 third retired", order[b_ord + 2], 1);

        // Graph 2: node 3 unreachable.
        wmem[1][3] = 8'hFF;
        b_rd = rd_cnt; b_s3 = src3_reads;
        pulse_start(2'd0, "g2");
        wait_done("g2");
        chk("g2 dist", dist_vector, 32'hFF01_0300);
        chk("g2 visited", visited_vector, 4'b0111);
        chk("g2 node3 reads", src3_reads - b_s3, 0);
        chk("g2 edge reads", rd_cnt - b_rd, 12);

        // Saturation: 1->2 sum 300 must not wrap to 44.
        clear_graph();
        wmem[0][1] = 8'd200; wmem[1][2] = 8'd100; wmem[0][2] = 8'd250;
        pulse_start(2'd0, "sat");
        wait_done("sat");
        chk("sat dist", dist_vector, 32'hFFFA_C800);
        chk("sat visited", visited_vector, 4'b0111);

        // Stale handshake on the second set_en of the run.
        clear_graph();
        wmem[0][1] = 8'd4; wmem[0][2] = 8'd1; wmem[2][1] = 8'd2; wmem[1][3] = 8'd5;
        b_ord = order.size();
        stale_sen = sen_cnt + 2;
        stale_en = 1'b1;
        pulse_start(2'd0, "stale");
        wait_done("stale");
        stale_en = 1'b0;
        chk("stale second retired", order[b_ord + 1], 2);
        chk("stale dist", dist_vector, 32'h0801_0300);

        // Stray start during RELAX is ignored.
        b_sen = sen_cnt;
        pulse_start(2'd0, "stray");
        wait_relax("stray");
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("stray set_en", set_en, 0);
        chk("stray busy", busy, 1);
        wait_done("stray");
        chk("stray dist", dist_vector, 32'h0801_0300);
        chk("stray set_en pulses", sen_cnt - b_sen, 4);

        // Restart from DONE with a different source.
        pulse_start(2'd2, "src2");
        wait_done("src2");
        chk("src2 dist", dist_vector, 32'h0700_02FF);
        chk("src2 visited", visited_vector, 4'b1110);

        // Asynchronous reset mid-RELAX.
        pulse_start(2'd0, "arst");
        wait_relax("arst");
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("arst dist", dist_vector, 32'hFFFF_FFFF);
        chk("arst visited", visited_vector, 0);
        chk("arst busy", busy, 0);
        chk("arst done", done, 0);
        chk("arst edge_rd_en", edge_rd_en, 0);
        chk("arst set_en", set_en, 0);
        @(negedge clock);
        reset = 1'b1;
        pulse_start(2'd0, "post");
        wait_done("post");
        chk("post dist", dist_vector, 32'h0801_0300);
        chk("post visited", visited_vector, 4'b1111);
        chk("set_en never consecutive", consec_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/dijkstra_relaxer.md
Name: dijkstra_relaxer

Overview:
- Dijkstra control and relaxation engine; the consumer of the MinHeap min-select interface.
- Owns the distance and visited vectors and drives them, with set_en, into MinHeap.
- Waits for min_ready, retires the reported node, relaxes its outgoing edges from an external edge-weight memory, then requests the next minimum.
- Reports done when every reachable node is finalized.

Parameters:
MAX_NODES, 8, number of graph nodes
INDEX_WIDTH, 3, node index width (clog2 MAX_NODES)
VALUE_WIDTH, 8, distance/weight width; all-ones = INF (no edge / unreached)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse; begin search from source_index
source_index  in  INDEX_WIDTH  source node, sampled when start accepted
min_ready  in  1  MinHeap result valid
sc_min_index  in  INDEX_WIDTH  MinHeap minimum unvisited node
sc_min_value  in  VALUE_WIDTH  distance of sc_min_index
set_en  out  1  pulse telling MinHeap the vectors changed
visited_vector  out  MAX_NODES  bit n = node n finalized
dist_vector  out  VALUE_WIDTH x MAX_NODES  current tentative distances
edge_rd_en  out  1  edge memory read strobe
edge_src  out  INDEX_WIDTH  edge row (from node)
edge_dst  out  INDEX_WIDTH  edge column (to node)
edge_weight  in  VALUE_WIDTH  read data, valid exactly 1 cycle after edge_rd_en; INF = no edge
busy  out  1  search in progress
done  out  1  search complete; held until next accepted start

Behaviour:
- Reset (reset low, async): state IDLE; dist_vector all INF; visited_vector 0; set_en, edge_rd_en, busy, done 0; edge_src/edge_dst 0.
- All outputs registered.
- IDLE/DONE: start=1 -> INIT. start in any other state is ignored.
- INIT (1 cycle):
  - dist all INF except dist[source_index]=0; visited 0.
  - set_en=1 for this cycle; done=0, busy=1.
  - -> WAIT_MIN.
- WAIT_MIN:
  - Clear armed flag on entry.
  - min_ready==0 sets armed.
  - min_ready==1 is accepted only when armed. This rejects the stale result still presented for one cycle after set_en.
  - On accept: latch sc_min_index as cur, sc_min_value as curd. -> CHECK.
- CHECK (1 cycle):
  - curd==INF -> DONE; remaining nodes unreachable, left unvisited at INF.
  - Otherwise set visited[cur]=1 -> RELAX, with j=0.
- RELAX (pipelined, MAX_NODES+1 cycles):
  - Cycle t (t<MAX_NODES): edge_rd_en=1, edge_src=cur, edge_dst=t.
  - Cycle t+1: evaluate column t:
    - sum = curd + edge_weight in VALUE_WIDTH+1 bits.
    - Update dist[t]=sum[VALUE_WIDTH-1:0] iff edge_weight!=INF, visited[t]==0, sum<INF, and sum<dist[t].
    - Saturated sums (>=INF) never update.
    - Self-edge is excluded by visited[cur]=1.
  - edge_rd_en low in the final cycle.
  - Then: visited all ones -> DONE; else set_en=1 for one cycle -> WAIT_MIN.
- DONE: busy=0, done=1; vectors held stable for readout.
- Invariants:
  - set_en is never high for two consecutive cycles.
  - visited_vector changes only in CHECK; dist_vector only in INIT/RELAX.
  - At most one outstanding edge read per cycle.
- Latency per retired node: WAIT_MIN (>= MinHeap settle, >=3 cycles) + 1 (CHECK) + MAX_NODES+1 (RELAX).
- Reset mid-operation: immediate return to reset state. An in-flight edge_weight is discarded.
- Equal distances: ties are resolved by MinHeap; the relaxer takes whatever index it reports.

Test Plan:
- MAX_NODES=4, VALUE_WIDTH=8; edges 0->1 w4, 0->2 w1, 2->1 w2, 1->3 w5, others INF; start, source 0.
  -> done; dist=[0,3,1,8]; visited=4'b1111; exactly 4 set_en pulses (INIT + 3 relax).
- Same graph without 1->3.
  -> dist=[0,3,1,255]; visited=4'b0111; done after sc_min_value=255 is seen; no edge reads for node 3.
- Saturation: source 0; 0->1 w200, 1->2 w100, 0->2 w250.
  -> 1->2 sum 300 saturates and is ignored; dist[2]=250, dist[1]=200.
- Stale handshake: bench heap model holds min_ready=1 continuously, with index 1 for 3 cycles after set_en, then drops for 1 cycle, then presents index 2.
  -> relaxer retires node 2, never the stale node 1.
- start pulsed during RELAX.
  -> ignored; results identical to the undisturbed run. start in DONE restarts cleanly with done dropping in INIT.
- reset asserted low mid-RELAX for 1 cycle.
  -> dist all 255, visited 0, busy 0, done 0, edge_rd_en 0 immediately (asynchronous). A subsequent start yields correct results.
